// File: rtl/reqrsp_mux_rr.sv
`default_nettype none
// =============================================================================
// Module   : reqrsp_mux_rr
// Brief    : Round-robin N:1 reqrsp multiplexer with in-order response routing.
//            Optional stall counter enabled by REQRSP_MUX_STALL_CNT_EN.
// Revision : 1.0 - initial release
// =============================================================================
module reqrsp_mux_rr #(
    parameter int unsigned NrPorts        = 4,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned StrbWidth     = DataWidth / 8,
    localparam int unsigned IdxWidth      = $clog2(NrPorts)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NrPorts-1:0][AddrWidth-1:0]   slv_q_addr_i,
    input  logic [NrPorts-1:0]                  slv_q_write_i,
    input  logic [NrPorts-1:0][3:0]             slv_q_amo_i,
    input  logic [NrPorts-1:0][DataWidth-1:0]   slv_q_data_i,
    input  logic [NrPorts-1:0][StrbWidth-1:0]   slv_q_strb_i,
    input  logic [NrPorts-1:0][1:0]             slv_q_size_i,
    input  logic [NrPorts-1:0]                  slv_q_valid_i,
    output logic [NrPorts-1:0]                  slv_q_ready_o,
    output logic [NrPorts-1:0][DataWidth-1:0]   slv_p_data_o,
    output logic [NrPorts-1:0]                  slv_p_error_o,
    output logic [NrPorts-1:0]                  slv_p_valid_o,
    input  logic [NrPorts-1:0]                  slv_p_ready_i,
    output logic [AddrWidth-1:0]                mst_q_addr_o,
    output logic                                mst_q_write_o,
    output logic [3:0]                          mst_q_amo_o,
    output logic [DataWidth-1:0]                mst_q_data_o,
    output logic [StrbWidth-1:0]                mst_q_strb_o,
    output logic [1:0]                          mst_q_size_o,
    output logic                                mst_q_valid_o,
    input  logic                                mst_q_ready_i,
    input  logic [DataWidth-1:0]                mst_p_data_i,
    input  logic                                mst_p_error_i,
    input  logic                                mst_p_valid_i,
    output logic                                mst_p_ready_o,
    output logic [31:0]                         stall_cnt_o
);

    localparam int unsigned c_PTR_WIDTH = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned c_CNT_WIDTH = $clog2(MaxOutstanding + 1);
    localparam logic [c_CNT_WIDTH-1:0] c_MAX_CNT  = c_CNT_WIDTH'(MaxOutstanding);
    localparam logic [c_PTR_WIDTH-1:0] c_LAST_PTR = c_PTR_WIDTH'(MaxOutstanding - 1);
    localparam logic [IdxWidth-1:0]    c_LAST_IDX = IdxWidth'(NrPorts - 1);

    logic [IdxWidth-1:0]                      rr_ptr_q, rr_ptr_d;
    logic                                     lock_q, lock_d;
    logic [IdxWidth-1:0]                      lock_idx_q, lock_idx_d;
    logic [MaxOutstanding-1:0][IdxWidth-1:0]  fifo_mem_q;
    logic [c_PTR_WIDTH-1:0]                   wr_ptr_q, wr_ptr_d;
    logic [c_PTR_WIDTH-1:0]                   rd_ptr_q, rd_ptr_d;
    logic [c_CNT_WIDTH-1:0]                   cnt_q, cnt_d;

    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_push;
    logic                w_pop;
    logic [IdxWidth-1:0] w_cand;
    logic [IdxWidth-1:0] w_arb_idx;
    logic                w_arb_found;
    logic [IdxWidth-1:0] w_gnt_idx;
    logic                w_gnt_any;
    logic [IdxWidth-1:0] w_head;

    assign w_fifo_full  = (cnt_q == c_MAX_CNT);
    assign w_fifo_empty = (cnt_q == '0);

    // Round-robin search starting at the pointer; first valid requester wins.
    always_comb begin
        w_cand      = rr_ptr_q;
        w_arb_idx   = rr_ptr_q;
        w_arb_found = 1'b0;
        for (int unsigned i = 0; i < NrPorts; i++) begin
            w_cand = IdxWidth'((32'(rr_ptr_q) + i) % NrPorts);
            if (!w_arb_found && slv_q_valid_i[w_cand]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_cand;
            end
        end
    end

    assign w_gnt_idx = lock_q ? lock_idx_q : w_arb_idx;
    assign w_gnt_any = lock_q | w_arb_found;

    assign mst_q_addr_o  = slv_q_addr_i[w_gnt_idx];
    assign mst_q_write_o = slv_q_write_i[w_gnt_idx];
    assign mst_q_amo_o   = slv_q_amo_i[w_gnt_idx];
    assign mst_q_data_o  = slv_q_data_i[w_gnt_idx];
    assign mst_q_strb_o  = slv_q_strb_i[w_gnt_idx];
    assign mst_q_size_o  = slv_q_size_i[w_gnt_idx];
    assign mst_q_valid_o = !rst_i && w_gnt_any && slv_q_valid_i[w_gnt_idx] && !w_fifo_full;

    always_comb begin
        slv_q_ready_o = '0;
        if (!rst_i && mst_q_ready_i && !w_fifo_full) begin
            slv_q_ready_o[w_gnt_idx] = 1'b1;
        end
    end

    assign w_push = mst_q_valid_o && mst_q_ready_i;

    // Responses return in issue order, so the FIFO head names the issuer.
    assign w_head        = fifo_mem_q[rd_ptr_q];
    assign mst_p_ready_o = !rst_i && !w_fifo_empty && slv_p_ready_i[w_head];
    assign w_pop         = mst_p_valid_i && mst_p_ready_o;

    always_comb begin
        slv_p_valid_o = '0;
        if (!rst_i && mst_p_valid_i && !w_fifo_empty) begin
            slv_p_valid_o[w_head] = 1'b1;
        end
    end

    assign slv_p_data_o  = {NrPorts{mst_p_data_i}};
    assign slv_p_error_o = {NrPorts{mst_p_error_i}};

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (w_push) begin
            lock_d   = 1'b0;
            rr_ptr_d = (w_gnt_idx == c_LAST_IDX) ? '0 : w_gnt_idx + IdxWidth'(1);
        end else if (mst_q_valid_o) begin
            lock_d     = 1'b1;
            lock_idx_d = w_gnt_idx;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (w_push) begin
            wr_ptr_d = (wr_ptr_q == c_LAST_PTR) ? '0 : wr_ptr_q + c_PTR_WIDTH'(1);
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == c_LAST_PTR) ? '0 : rd_ptr_q + c_PTR_WIDTH'(1);
        end
        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + c_CNT_WIDTH'(1);
            2'b01:   cnt_d = cnt_q - c_CNT_WIDTH'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read while the count covers them.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= w_gnt_idx;
        end
    end

`ifdef REQRSP_MUX_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (|slv_q_valid_i && w_fifo_full && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

    a_no_rsp_when_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        !(mst_p_valid_i && w_fifo_empty));

endmodule
`default_nettype wire

// File: tb/tb_reqrsp_mux_rr.sv
`default_nettype none
// =============================================================================
// Module   : tb_reqrsp_mux_rr
// Brief    : Directed self-checking bench for reqrsp_mux_rr (default parameters).
// Revision : 1.0 - initial release
// =============================================================================
module tb_reqrsp_mux_rr;

    localparam int unsigned NP = 4;

`ifdef REQRSP_MUX_STALL_CNT_EN
    localparam logic [31:0] c_STALL_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] c_STALL_MASK = 32'h0;
`endif

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic [NP-1:0][31:0] slv_q_addr_i;
    logic [NP-1:0]       slv_q_write_i;
    logic [NP-1:0][3:0]  slv_q_amo_i;
    logic [NP-1:0][31:0] slv_q_data_i;
    logic [NP-1:0][3:0]  slv_q_strb_i;
    logic [NP-1:0][1:0]  slv_q_size_i;
    logic [NP-1:0]       slv_q_valid_i;
    logic [NP-1:0]       slv_q_ready_o;
    logic [NP-1:0][31:0] slv_p_data_o;
    logic [NP-1:0]       slv_p_error_o;
    logic [NP-1:0]       slv_p_valid_o;
    logic [NP-1:0]       slv_p_ready_i;
    logic [31:0]         mst_q_addr_o;
    logic                mst_q_write_o;
    logic [3:0]          mst_q_amo_o;
    logic [31:0]         mst_q_data_o;
    logic [3:0]          mst_q_strb_o;
    logic [1:0]          mst_q_size_o;
    logic                mst_q_valid_o;
    logic                mst_q_ready_i;
    logic [31:0]         mst_p_data_i;
    logic                mst_p_error_i;
    logic                mst_p_valid_i;
    logic                mst_p_ready_o;
    logic [31:0]         stall_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    reqrsp_mux_rr u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .slv_q_addr_i  (slv_q_addr_i),
        .slv_q_write_i (slv_q_write_i),
        .slv_q_amo_i   (slv_q_amo_i),
        .slv_q_data_i  (slv_q_data_i),
        .slv_q_strb_i  (slv_q_strb_i),
        .slv_q_size_i  (slv_q_size_i),
        .slv_q_valid_i (slv_q_valid_i),
        .slv_q_ready_o (slv_q_ready_o),
        .slv_p_data_o  (slv_p_data_o),
        .slv_p_error_o (slv_p_error_o),
        .slv_p_valid_o (slv_p_valid_o),
        .slv_p_ready_i (slv_p_ready_i),
        .mst_q_addr_o  (mst_q_addr_o),
        .mst_q_write_o (mst_q_write_o),
        .mst_q_amo_o   (mst_q_amo_o),
        .mst_q_data_o  (mst_q_data_o),
        .mst_q_strb_o  (mst_q_strb_o),
        .mst_q_size_o  (mst_q_size_o),
        .mst_q_valid_o (mst_q_valid_o),
        .mst_q_ready_i (mst_q_ready_i),
        .mst_p_data_i  (mst_p_data_i),
        .mst_p_error_i (mst_p_error_i),
        .mst_p_valid_i (mst_p_valid_i),
        .mst_p_ready_o (mst_p_ready_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic exp_grant(input string tag, input int p);
        check_eq({tag, "_qvalid"}, 64'(mst_q_valid_o), 64'd1);
        check_eq({tag, "_addr"},   64'(mst_q_addr_o),  64'(32'h1000 + 32'(p) * 32'h100));
        check_eq({tag, "_data"},   64'(mst_q_data_o),  64'(32'hD0 + 32'(p)));
        check_eq({tag, "_amo"},    64'(mst_q_amo_o),   64'(p));
        check_eq({tag, "_qready"}, 64'(slv_q_ready_o), 64'(1) << p);
    endtask

    task automatic exp_rsp(input string tag, input int p, input logic [31:0] data);
        check_eq({tag, "_pvalid"}, 64'(slv_p_valid_o),   64'(1) << p);
        check_eq({tag, "_pdata"},  64'(slv_p_data_o[p]), 64'(data));
        check_eq({tag, "_pready"}, 64'(mst_p_ready_o),   64'd1);
    endtask

    initial begin
        rst_i         = 1'b1;
        slv_q_valid_i = '0;
        slv_p_ready_i = '0;
        mst_q_ready_i = 1'b0;
        mst_p_data_i  = '0;
        mst_p_error_i = 1'b0;
        mst_p_valid_i = 1'b0;
        for (int p = 0; p < NP; p++) begin
            slv_q_addr_i[p]  = 32'h1000 + 32'(p) * 32'h100;
            slv_q_data_i[p]  = 32'hD0 + 32'(p);
            slv_q_amo_i[p]   = 4'(p);
            slv_q_write_i[p] = p[0];
            slv_q_strb_i[p]  = 4'hF;
            slv_q_size_i[p]  = 2'd2;
        end

        // Reset: outputs quiet even with traffic presented.
        step();
        slv_q_valid_i = 4'b1111;
        mst_q_ready_i = 1'b1;
        slv_p_ready_i = 4'b1111;
        #1;
        check_eq("rst_qvalid", 64'(mst_q_valid_o), 64'd0);
        check_eq("rst_qready", 64'(slv_q_ready_o), 64'd0);
        check_eq("rst_pvalid", 64'(slv_p_valid_o), 64'd0);
        check_eq("rst_pready", 64'(mst_p_ready_o), 64'd0);
        check_eq("rst_stall",  64'(stall_cnt_o),   64'd0);
        step();
        rst_i = 1'b0;
        #1;

        // Round robin 0,1,2,3,0 with responses two cycles behind.
        exp_grant("rr_c0", 0);
        step(); #1;
        exp_grant("rr_c1", 1);
        step();
        mst_p_valid_i = 1'b1;
        mst_p_data_i  = 32'hA0;
        #1;
        exp_grant("rr_c2", 2);
        exp_rsp("rr_c2", 0, 32'hA0);
        step();
        mst_p_data_i = 32'hA1;
        #1;
        exp_grant("rr_c3", 3);
        exp_rsp("rr_c3", 1, 32'hA1);
        step();
        mst_p_data_i = 32'hA2;
        #1;
        exp_grant("rr_c4", 0);
        exp_rsp("rr_c4", 2, 32'hA2);
        step();
        slv_q_valid_i = '0;
        mst_p_data_i  = 32'hA3;
        #1;
        check_eq("rr_c5_qvalid", 64'(mst_q_valid_o), 64'd0);
        exp_rsp("rr_c5", 3, 32'hA3);
        step();
        mst_p_data_i = 32'hA0;
        #1;
        exp_rsp("rr_c6", 0, 32'hA0);
        step();
        mst_p_valid_i = 1'b0;
        #1;
        check_eq("rr_empty_pvalid", 64'(slv_p_valid_o), 64'd0);
        check_eq("rr_empty_pready", 64'(mst_p_ready_o), 64'd0);

        // Lock: port 2 held while ports 0 and 1 join during backpressure.
        step();
        slv_q_valid_i = 4'b0100;
        mst_q_ready_i = 1'b0;
        #1;
        check_eq("lock_c0_qvalid", 64'(mst_q_valid_o), 64'd1);
        check_eq("lock_c0_addr",   64'(mst_q_addr_o),  64'h1200);
        check_eq("lock_c0_qready", 64'(slv_q_ready_o), 64'd0);
        for (int i = 1; i < 5; i++) begin
            step();
            slv_q_valid_i = 4'b0111;
            #1;
            check_eq($sformatf("lock_c%0d_addr", i),   64'(mst_q_addr_o),  64'h1200);
            check_eq($sformatf("lock_c%0d_qready", i), 64'(slv_q_ready_o), 64'd0);
        end
        step();
        mst_q_ready_i = 1'b1;
        #1;
        exp_grant("lock_hs", 2);
        step();
        slv_q_valid_i = 4'b0001;
        #1;
        exp_grant("lock_next", 0);

        // Response backpressure on the head port (2).
        step();
        slv_q_valid_i = '0;
        mst_p_valid_i = 1'b1;
        mst_p_data_i  = 32'hB2;
        slv_p_ready_i = 4'b1011;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("pbp_c%0d_pready", i), 64'(mst_p_ready_o), 64'd0);
            check_eq($sformatf("pbp_c%0d_pvalid", i), 64'(slv_p_valid_o), 64'b0100);
            step();
        end
        slv_p_ready_i = 4'b1111;
        #1;
        exp_rsp("pbp_rel", 2, 32'hB2);
        step();
        mst_p_data_i = 32'hB0;
        #1;
        exp_rsp("pbp_next", 0, 32'hB0);
        step();
        mst_p_valid_i = 1'b0;

        // Outstanding limit: port 1 fills the FIFO, then stalls.
        slv_q_valid_i = 4'b0010;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_grant($sformatf("full_push%0d", i), 1);
            step();
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("full_c%0d_qvalid", i), 64'(mst_q_valid_o), 64'd0);
            check_eq($sformatf("full_c%0d_qready", i), 64'(slv_q_ready_o), 64'd0);
            step();
        end
        mst_p_valid_i = 1'b1;
        mst_p_data_i  = 32'hC1;
        #1;
        check_eq("full_pop_qvalid", 64'(mst_q_valid_o), 64'd0);
        check_eq("full_stall3",     64'(stall_cnt_o),   64'(32'd3 & c_STALL_MASK));
        exp_rsp("full_pop", 1, 32'hC1);
        step();
        mst_p_valid_i = 1'b0;
        #1;
        check_eq("full_stall4", 64'(stall_cnt_o), 64'(32'd4 & c_STALL_MASK));
        exp_grant("full_refill", 1);
        step();
        slv_q_valid_i = '0;
        mst_p_valid_i = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_rsp($sformatf("full_drain%0d", i), 1, 32'hC1);
            step();
        end
        mst_p_valid_i = 1'b0;
        #1;
        check_eq("full_stall_hold", 64'(stall_cnt_o), 64'(32'd4 & c_STALL_MASK));

        // Error response for a port-3 write.
        slv_q_valid_i = 4'b1000;
        #1;
        exp_grant("err_req", 3);
        check_eq("err_req_write", 64'(mst_q_write_o), 64'd1);
        step();
        slv_q_valid_i = '0;
        mst_p_valid_i = 1'b1;
        mst_p_error_i = 1'b1;
        mst_p_data_i  = 32'hEE;
        #1;
        exp_rsp("err_rsp", 3, 32'hEE);
        check_eq("err_rsp_error", 64'(slv_p_error_o[3]), 64'd1);
        step();
        mst_p_valid_i = 1'b0;
        mst_p_error_i = 1'b0;

        // Reset with three outstanding and pointer at 3.
        slv_q_valid_i = 4'b0111;
        #1;
        for (int i = 0; i < 3; i++) begin
            exp_grant($sformatf("rst_push%0d", i), i);
            step();
        end
        slv_q_valid_i = '0;
        #1;
        check_eq("rst_pre_pready", 64'(mst_p_ready_o), 64'd1);
        step();
        rst_i         = 1'b1;
        slv_q_valid_i = 4'b1111;
        #1;
        check_eq("rst_mid_qvalid", 64'(mst_q_valid_o), 64'd0);
        check_eq("rst_mid_pready", 64'(mst_p_ready_o), 64'd0);
        step();
        rst_i         = 1'b0;
        slv_q_valid_i = '0;
        #1;
        check_eq("rst_post_qvalid", 64'(mst_q_valid_o), 64'd0);
        check_eq("rst_post_pvalid", 64'(slv_p_valid_o), 64'd0);
        check_eq("rst_post_pready", 64'(mst_p_ready_o), 64'd0);
        check_eq("rst_post_stall",  64'(stall_cnt_o),   64'd0);
        step();
        slv_q_valid_i = 4'b1111;
        #1;
        exp_grant("rst_post_ptr", 0);
        step();
        slv_q_valid_i = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reqrsp_mux_rr.md
Name: reqrsp_mux_rr

Overview:
- N-to-1 multiplexer for the two-channel request/response bus (Q request, P response, valid/ready on each).
- Arbitrates N requester ports onto one downstream port using round-robin.
- Routes each response back to its issuer through an in-order ID FIFO, with a bounded number of outstanding transactions.
- Sits between core/accelerator ports and a shared TCDM/peripheral reqrsp target.

Parameters:
- NrPorts, 4, number of upstream requester ports (>=2).
- AddrWidth, 32, Q address width.
- DataWidth, 32, Q/P data width; StrbWidth = DataWidth/8.
- MaxOutstanding, 4, depth of the response-routing FIFO (>=1).
- IdxWidth, derived, $clog2(NrPorts).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- slv_q_addr_i  in  NrPorts x AddrWidth  per-port request address
- slv_q_write_i  in  NrPorts  1=write/amo, 0=read
- slv_q_amo_i  in  NrPorts x 4  amo_op_e
- slv_q_data_i  in  NrPorts x DataWidth  write data
- slv_q_strb_i  in  NrPorts x StrbWidth  byte strobe
- slv_q_size_i  in  NrPorts x 2  size_t
- slv_q_valid_i  in  NrPorts  request valid
- slv_q_ready_o  out  NrPorts  request ready
- slv_p_data_o  out  NrPorts x DataWidth  response data
- slv_p_error_o  out  NrPorts  response error
- slv_p_valid_o  out  NrPorts  response valid
- slv_p_ready_i  in  NrPorts  response ready
- mst_q_addr_o, mst_q_write_o, mst_q_amo_o, mst_q_data_o, mst_q_strb_o, mst_q_size_o  out  (single-port widths as above)  downstream request fields
- mst_q_valid_o  out  1  downstream request valid
- mst_q_ready_i  in  1  downstream request ready
- mst_p_data_i  in  DataWidth  downstream response data
- mst_p_error_i  in  1  downstream response error
- mst_p_valid_i  in  1  downstream response valid
- mst_p_ready_o  out  1  downstream response ready
- stall_cnt_o  out  32  stall counter (see Optional Feature)

Behaviour:
- Clocking: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset: mst_q_valid_o=0, slv_q_ready_o=0, slv_p_valid_o=0, mst_p_ready_o=0, RR pointer=0, lock cleared, FIFO empty, stall_cnt_o=0. Data outputs are don't-care while the corresponding valid is low.
- Arbitration: round-robin among asserted slv_q_valid_i, starting the search at the pointer. After a Q handshake, pointer = granted index + 1 (wraps NrPorts-1 -> 0).
- Lock: once mst_q_valid_o rises for index k, the grant stays on k until mst_q_ready_i. No re-arbitration and no field change while valid && !ready, preserving the bus stability rule.
- Request path: combinational, zero-latency. mst_q_* = slv_q_*[k]. mst_q_valid_o = slv_q_valid_i[k] && !fifo_full. slv_q_ready_o[k] = mst_q_ready_i && !fifo_full; all other ready bits are 0. valid never depends on ready.
- FIFO push: index k on each Q handshake (reads, writes and AMOs all produce a response).
- FIFO full: mst_q_valid_o is held 0 and no grant/lock is taken. A push when full is never accepted, even if a pop occurs in the same cycle (no fall-through).
- Response path: h = FIFO head. slv_p_valid_o[h] = mst_p_valid_i && !fifo_empty. slv_p_data_o/slv_p_error_o are broadcast to all ports, with valid only on h. mst_p_ready_o = slv_p_ready_i[h] && !fifo_empty. Pop on P handshake.
- Simultaneous push and pop when not full: both happen; occupancy is unchanged.
- FIFO empty with mst_p_valid_i=1: protocol violation. mst_p_ready_o=0 and a simulation assertion fires.
- Same-cycle Q response (downstream with 0 latency) is unsupported; a P handshake requires a prior-cycle push.
- Reset mid-transaction: FIFO and lock are discarded. Downstream must be reset concurrently.
- Occupancy counter is $clog2(MaxOutstanding+1) bits wide, with no wrap.

Optional Feature:
- Macro REQRSP_MUX_STALL_CNT_EN.
- Defined: stall_cnt_o is a 32-bit saturating counter (sticks at 0xFFFF_FFFF). It increments each cycle where |slv_q_valid_i && fifo_full, and clears on rst_i.
- Undefined: stall_cnt_o is tied to 0 and no counter flops exist.

Test Plan:
- Ports 0..3 all valid, mst_q_ready_i=1, responses returned 2 cycles later -> grants in order 0,1,2,3,0; each slv_p_valid_o pulses on the matching port with data 0xA0+idx.
- Port 2 valid, mst_q_ready_i=0 for 5 cycles while port 0 also asserts valid -> mst_q_addr_o stays at port 2's address for all 5 cycles; grant moves to 0 only after the handshake.
- MaxOutstanding=4, no responses, port 1 issues 6 requests -> 4 accepted, then mst_q_valid_o=0. With the macro defined, stall_cnt_o counts the stall cycles (e.g. 10 after 10 cycles). After one response, the 5th request is accepted the next cycle.
- Responses with slv_p_ready_i[h]=0 for 3 cycles -> mst_p_ready_o=0 throughout; no pop; FIFO head unchanged.
- mst_p_error_i=1 on the response for a port-3 write -> slv_p_error_o=1 seen with slv_p_valid_o[3]=1 only.
- Assert rst_i for 1 cycle with 3 outstanding -> the next cycle all valids are 0, the FIFO is empty, and the pointer is 0.
